// File: rtl/operand_fetch_ctrl.sv
// Operand fetch sequencer: steps the external 4:1 mux select through two sources,
// captures both operands and offers the pair to the ALU. Optional: OPERAND_FETCH_SAME_SRC_BYPASS_EN.
//
// state   | meaning
// IDLE    | waiting for an operand request, instr_ready high
// FETCH_A | Sel = src_a, capture operand A this cycle
// FETCH_B | Sel = latched src_b, capture operand B this cycle
// HOLD    | pair valid, waiting for op_ready
module operand_fetch_ctrl #(
  parameter int DATA_W = 16,
  parameter int SEL_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [SEL_W-1:0]  src_a,
  input  logic [SEL_W-1:0]  src_b,
  output logic [SEL_W-1:0]  Sel,
  input  logic [DATA_W-1:0] mux_out,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic              op_valid,
  input  logic              op_ready
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH_A = 2'd1,
    FETCH_B = 2'd2,
    HOLD    = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [SEL_W-1:0]  src_b_q, src_b_nxt, sel_nxt;
  logic [DATA_W-1:0] op_a_nxt, op_b_nxt;
  logic              op_valid_nxt;

`ifdef OPERAND_FETCH_SAME_SRC_BYPASS_EN
  logic same_q, same_nxt;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (instr_valid) state_nxt = FETCH_A;
`ifdef OPERAND_FETCH_SAME_SRC_BYPASS_EN
      FETCH_A: state_nxt = same_q ? HOLD : FETCH_B;
`else
      FETCH_A: state_nxt = FETCH_B;
`endif
      FETCH_B: state_nxt = HOLD;
      HOLD:    if (op_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values for the registered outputs; everything holds unless the state says otherwise.
  always_comb begin
    sel_nxt      = Sel;
    src_b_nxt    = src_b_q;
    op_a_nxt     = op_a;
    op_b_nxt     = op_b;
    op_valid_nxt = op_valid;
`ifdef OPERAND_FETCH_SAME_SRC_BYPASS_EN
    same_nxt     = same_q;
`endif
    case (state)
      IDLE: begin
        if (instr_valid) begin
          sel_nxt   = src_a;
          src_b_nxt = src_b;
`ifdef OPERAND_FETCH_SAME_SRC_BYPASS_EN
          same_nxt  = (src_a == src_b);
`endif
        end
      end
      FETCH_A: begin
        op_a_nxt = mux_out;
`ifdef OPERAND_FETCH_SAME_SRC_BYPASS_EN
        if (same_q) begin
          op_b_nxt     = mux_out;
          op_valid_nxt = 1'b1;
        end else begin
          sel_nxt = src_b_q;
        end
`else
        sel_nxt = src_b_q;
`endif
      end
      FETCH_B: begin
        op_b_nxt     = mux_out;
        op_valid_nxt = 1'b1;
      end
      HOLD: begin
        if (op_ready) op_valid_nxt = 1'b0;
      end
      default: op_valid_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      Sel      <= '0;
      src_b_q  <= '0;
      op_a     <= '0;
      op_b     <= '0;
      op_valid <= 1'b0;
    end else begin
      Sel      <= sel_nxt;
      src_b_q  <= src_b_nxt;
      op_a     <= op_a_nxt;
      op_b     <= op_b_nxt;
      op_valid <= op_valid_nxt;
    end
  end

`ifdef OPERAND_FETCH_SAME_SRC_BYPASS_EN
  always_ff @(posedge clk) begin
    if (rst) same_q <= 1'b0;
    else     same_q <= same_nxt;
  end
`endif

  assign instr_ready = (state == IDLE);

endmodule

// File: tb/tb_operand_fetch_ctrl.sv
// Self-checking bench for operand_fetch_ctrl: directed scenarios plus random traffic,
// compared each cycle against a transaction-level model timed from the accept edge.
module tb_operand_fetch_ctrl;

  localparam int DATA_W = 16;
  localparam int SEL_W  = 2;
`ifdef OPERAND_FETCH_SAME_SRC_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst, instr_valid, instr_ready, op_valid, op_ready;
  logic [SEL_W-1:0]  src_a, src_b, Sel;
  logic [DATA_W-1:0] mux_out, op_a, op_b;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] mux_val(input logic [SEL_W-1:0] s);
    case (s)
      2'd0:    return 16'h000F;
      2'd1:    return 16'h00F0;
      2'd2:    return 16'h0F00;
      default: return 16'hF000;
    endcase
  endfunction

  // Stand-in for the external mux_4x1 driven by the block's Sel.
  always_comb mux_out = mux_val(Sel);

  operand_fetch_ctrl #(.DATA_W(DATA_W), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .src_a(src_a), .src_b(src_b), .Sel(Sel), .mux_out(mux_out),
    .op_a(op_a), .op_b(op_b), .op_valid(op_valid), .op_ready(op_ready)
  );

  // Reference model: a request is "in flight" from its accept edge; edge count k is
  // 1 at accept, operand A lands on k=2, operand B and valid on k=3 (k=2 for bypass).
  bit                m_busy, m_valid, m_same;
  int                m_k;
  logic [SEL_W-1:0]  m_sel, m_pend_sel_b;
  logic [DATA_W-1:0] m_a, m_b, m_pend_a, m_pend_b;

  task automatic model_edge();
    if (rst) begin
      m_busy = 0; m_valid = 0; m_same = 0; m_k = 0;
      m_sel = '0; m_a = '0; m_b = '0;
    end else if (!m_busy) begin
      if (instr_valid) begin
        m_busy = 1; m_k = 1;
        m_pend_a = mux_val(src_a);
        m_pend_b = mux_val(src_b);
        m_pend_sel_b = src_b;
        m_same = BYPASS && (src_a == src_b);
        m_sel = src_a;
      end
    end else if (m_valid) begin
      if (op_ready) begin
        m_valid = 0; m_busy = 0;
      end
    end else begin
      m_k++;
      if (m_k == 2) begin
        m_a = m_pend_a;
        if (m_same) begin
          m_b = m_pend_a; m_valid = 1;
        end else begin
          m_sel = m_pend_sel_b;
        end
      end else if (m_k == 3) begin
        m_b = m_pend_b; m_valid = 1;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check("instr_ready", 32'(instr_ready), 32'(!m_busy));
    check("Sel",         32'(Sel),         32'(m_sel));
    check("op_a",        32'(op_a),        32'(m_a));
    check("op_b",        32'(op_b),        32'(m_b));
    check("op_valid",    32'(op_valid),    32'(m_valid));
  endtask

  // One clock: apply inputs, clock edge, advance the model, compare away from the edge.
  task automatic cyc(input bit iv, input logic [1:0] sa, input logic [1:0] sb,
                     input bit ordy, input bit r);
    instr_valid = iv; src_a = sa; src_b = sb; op_ready = ordy; rst = r;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  int pulses;

  initial begin
    rst = 1'b1; instr_valid = 0; op_ready = 0; src_a = '0; src_b = '0;
    @(negedge clk);

    // Reset: two edges with rst high.
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    check("reset_ready", 32'(instr_ready), 32'd1);
    check("reset_valid", 32'(op_valid),    32'd0);

    // Basic request 01/11, held off by op_ready low for a while.
    cyc(1, 2'b01, 2'b11, 0, 0);
    check("basic_sel_a", 32'(Sel), 32'h1);
    cyc(0, 2'b00, 2'b00, 0, 0);
    check("basic_sel_b", 32'(Sel), 32'h3);
    cyc(0, 2'b00, 2'b00, 0, 0);
    check("basic_valid", 32'(op_valid), 32'd1);
    check("basic_op_a",  32'(op_a), 32'h00F0);
    check("basic_op_b",  32'(op_b), 32'hF000);
    repeat (3) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    check("basic_ready_after", 32'(instr_ready), 32'd1);

    // Busy ignore: second request raised during FETCH_A and held until taken.
    cyc(1, 2'b01, 2'b11, 0, 0);
    cyc(1, 2'b10, 2'b00, 0, 0);
    cyc(1, 2'b10, 2'b00, 0, 0);
    check("busy_first_a", 32'(op_a), 32'h00F0);
    check("busy_first_b", 32'(op_b), 32'hF000);
    cyc(1, 2'b10, 2'b00, 1, 0);
    cyc(1, 2'b10, 2'b00, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 0);
    check("busy_second_a", 32'(op_a), 32'h0F00);
    check("busy_second_b", 32'(op_b), 32'h000F);
    cyc(0, 0, 0, 1, 0);

    // Same source 10/10.
    cyc(1, 2'b10, 2'b10, 0, 0);
    cyc(0, 0, 0, 0, 0);
    check("same_latency2", 32'(op_valid), 32'(BYPASS));
    cyc(0, 0, 0, 0, 0);
    check("same_op_a", 32'(op_a), 32'h0F00);
    check("same_op_b", 32'(op_b), 32'h0F00);
    check("same_valid", 32'(op_valid), 32'd1);
    cyc(0, 0, 0, 1, 0);

    // Reset while in FETCH_B: the pair is discarded.
    cyc(1, 2'b01, 2'b11, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    check("rst_mid_valid", 32'(op_valid), 32'd0);
    check("rst_mid_op_a",  32'(op_a), 32'h0);
    check("rst_mid_ready", 32'(instr_ready), 32'd1);
    repeat (4) cyc(0, 0, 0, 0, 0);

    // Back-to-back with both handshakes tied high: one pulse per 4 cycles.
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(1, 2'b00, 2'b01, 1, 0);
      if (op_valid) begin
        pulses++;
        check("b2b_op_a", 32'(op_a), 32'h000F);
        check("b2b_op_b", 32'(op_b), 32'h00F0);
      end
    end
    check("b2b_pulses", 32'(pulses), 32'd10);

    // Random traffic, including occasional resets and same-source requests.
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] ra, rb;
      ra = 2'($urandom_range(0, 3));
      rb = ($urandom_range(0, 3) == 0) ? ra : 2'($urandom_range(0, 3));
      cyc(bit'($urandom_range(0, 1)), ra, rb, bit'($urandom_range(0, 1)),
          $urandom_range(0, 49) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
